// File: rtl/enoc_switch_control_wormhole.sv
// enoc_switch_control_wormhole
// Per-output round-robin arbiter with wormhole locking for the ENoC crossbar.
// An output that grants a non-tail head stays locked to that input until the
// tail flit is granted.
// Optional macro PIPE_LINE_SA_EN registers o_output_grant by one cycle.
// Arbitration state is still updated from the unregistered grant.
module enoc_switch_control_wormhole #(
  parameter int N = 5,
  parameter int M = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic [0:M-1]          i_en,
  input  logic [0:N-1][0:M-1]   i_output_req,
  input  logic [0:N-1]          i_tail,
  output logic [0:M-1][0:N-1]   o_output_grant,
  output logic [0:M-1]          o_locked
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, LOCKED} st_t;

  logic [0:M-1][0:N-1] gnt;

  for (genvar j = 0; j < M; j++) begin : g_out
    st_t           st_q, st_d;
    logic [PW-1:0] ptr_q, ptr_d, own_q, own_d;
    logic [0:N-1]  req, g_d;

    // effective request column for this output, gated by downstream enable and ce
    always_comb begin
      req = '0;
      for (int i = 0; i < N; i++) req[i] = i_output_req[i][j] & i_en[j] & ce;
    end

    // arbitration: round-robin search when idle, owner-only when locked
    always_comb begin
      int   idx;
      logic found;
      st_d  = st_q;
      ptr_d = ptr_q;
      own_d = own_q;
      g_d   = '0;
      found = 1'b0;
      idx   = 0;
      if (st_q == IDLE) begin
        for (int off = 0; off < N; off++) begin
          idx = int'(ptr_q) + off;
          if (idx >= N) idx = idx - N;
          if (!found && req[idx]) begin
            found    = 1'b1;
            g_d[idx] = 1'b1;
            ptr_d    = PW'((idx + 1) % N);
            if (!i_tail[idx]) begin
              own_d = PW'(idx);
              st_d  = LOCKED;
            end
          end
        end
      end else if (req[own_q]) begin
        g_d[own_q] = 1'b1;
        if (i_tail[own_q]) st_d = IDLE;
      end
    end

    // state, pointer and owner registers; frozen while ce is low
    always_ff @(posedge clk) begin
      if (reset) begin
        st_q  <= IDLE;
        ptr_q <= '0;
        own_q <= '0;
      end else if (ce) begin
        st_q  <= st_d;
        ptr_q <= ptr_d;
        own_q <= own_d;
      end
    end

    assign gnt[j]      = g_d;
    assign o_locked[j] = (st_q == LOCKED);
  end

`ifdef PIPE_LINE_SA_EN
  logic [0:M-1][0:N-1] gnt_q;

  // registered grant toward the crossbar select lines
  always_ff @(posedge clk) begin
    if (reset)   gnt_q <= '0;
    else if (ce) gnt_q <= gnt;
  end

  assign o_output_grant = gnt_q;
`else
  assign o_output_grant = gnt;
`endif

endmodule

// File: tb/tb_enoc_switch_control_wormhole.sv
// Directed bench for enoc_switch_control_wormhole (N=M=5).
// Expected grants are queued when a step is driven and compared when the DUT
// presents them: same cycle normally, one cycle later with PIPE_LINE_SA_EN.
module tb_enoc_switch_control_wormhole;

  typedef logic [0:4][0:4] mat_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         ce = 1'b1;
  logic [0:4]   en = '1;
  mat_t         req = '0;
  logic [0:4]   tail = '0;
  mat_t         o_output_grant;
  logic [0:4]   o_locked;

  int passed = 0;
  int total  = 0;
  mat_t exp_q[$];
  mat_t last_g = '0;

  localparam logic [0:4] L0  = 5'b00000;
  localparam logic [0:4] L2  = 5'b00100;
  localparam logic [0:4] ALL = 5'b11111;

  enoc_switch_control_wormhole #(.N(5), .M(5)) dut (
    .clk(clk), .reset(reset), .ce(ce), .i_en(en),
    .i_output_req(req), .i_tail(tail),
    .o_output_grant(o_output_grant), .o_locked(o_locked)
  );

  always #5 clk = ~clk;

  function automatic mat_t rq(input int i, input int j);
    mat_t m = '0;
    m[i][j] = 1'b1;
    return m;
  endfunction

  // grant vector: output o granting input i
  function automatic mat_t gv(input int o, input int i);
    mat_t m = '0;
    m[o][i] = 1'b1;
    return m;
  endfunction

  function automatic logic [0:4] tb1(input int i);
    logic [0:4] t = '0;
    t[i] = 1'b1;
    return t;
  endfunction

  task automatic chk(input string tag, input logic [24:0] obs, input logic [24:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
  endtask

  task automatic pop_chk(input string tag);
    mat_t e;
    e = exp_q.pop_front();
    chk({tag, " grant"}, o_output_grant, e);
  endtask

  // one clock of stimulus; el is o_locked expected during this cycle
  task automatic step(input string tag, input mat_t r, input logic [0:4] tl,
                      input logic [0:4] e, input logic c, input mat_t eg,
                      input logic [0:4] el);
    @(negedge clk);
`ifdef PIPE_LINE_SA_EN
    if (exp_q.size() > 0) pop_chk(tag);
    if (!c) eg = last_g;
    last_g = eg;
`endif
    req = r; tail = tl; en = e; ce = c;
    exp_q.push_back(eg);
    #1;
    chk({tag, " locked"}, {20'b0, o_locked}, {20'b0, el});
`ifndef PIPE_LINE_SA_EN
    pop_chk(tag);
`endif
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
`ifdef PIPE_LINE_SA_EN
    if (exp_q.size() > 0) pop_chk("pre_reset");
`endif
    reset = 1'b1; req = '0; tail = '0; en = '1; ce = 1'b1;
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      chk("reset grant", o_output_grant, '0);
      chk("reset locked", {20'b0, o_locked}, 25'b0);
    end
    reset = 1'b0;
    last_g = '0;
  endtask

  initial begin
    do_reset(2);
    step("idle0", '0, L0, ALL, 1'b1, '0, L0);
    step("idle1", '0, L0, ALL, 1'b1, '0, L0);

    // round-robin on output 1, single-flit packets from inputs 0,2,4
    for (int k = 0; k < 6; k++)
      step("rr", rq(0,1) | rq(2,1) | rq(4,1), ALL, ALL, 1'b1,
           gv(1, (k % 3) * 2), L0);

    // two outputs granted in one cycle
    step("multi", rq(0,0) | rq(1,3), ALL, ALL, 1'b1, gv(0,0) | gv(3,1), L0);

    // move ptr[2] to 3 so input 3 wins over input 1
    step("prep", rq(2,2), tb1(2), ALL, 1'b1, gv(2,2), L0);

    // wormhole: input 3 four flits, input 1 single-flit contender
    step("wh1", rq(3,2) | rq(1,2), tb1(1), ALL, 1'b1, gv(2,3), L0);
    step("wh2", rq(3,2) | rq(1,2), tb1(1), ALL, 1'b1, gv(2,3), L2);
    step("wh3", rq(3,2) | rq(1,2), tb1(1), ALL, 1'b1, gv(2,3), L2);
    step("wh4", rq(3,2) | rq(1,2), tb1(1) | tb1(3), ALL, 1'b1, gv(2,3), L2);
    step("wh5", rq(1,2), tb1(1), ALL, 1'b1, gv(2,1), L0);

    // stall while locked (ptr[2]=2, input 3 wins)
    step("st1", rq(3,2) | rq(1,2), tb1(1), ALL, 1'b1, gv(2,3), L0);
    step("st2", rq(3,2) | rq(1,2), tb1(1), ALL, 1'b1, gv(2,3), L2);
    for (int k = 0; k < 3; k++)
      step("stall", rq(3,2) | rq(1,2), tb1(1), 5'b11011, 1'b1, '0, L2);
    step("noown", rq(1,2), tb1(1), ALL, 1'b1, '0, L2);
    step("st3", rq(3,2) | rq(1,2), tb1(1), ALL, 1'b1, gv(2,3), L2);
    step("st4", rq(3,2) | rq(1,2), tb1(1) | tb1(3), ALL, 1'b1, gv(2,3), L2);
    step("st5", rq(1,2), tb1(1), ALL, 1'b1, gv(2,1), L0);

    // ce gating mid-packet (ptr[2]=2)
    step("ce1", rq(3,2), L0, ALL, 1'b1, gv(2,3), L0);
    step("ce_off0", rq(3,2) | rq(1,2) | rq(0,1), tb1(3), ALL, 1'b0, '0, L2);
    step("ce_off1", rq(3,2) | rq(1,2) | rq(0,1), tb1(3), ALL, 1'b0, '0, L2);
    step("ce2", rq(3,2), tb1(3), ALL, 1'b1, gv(2,3), L2);
    step("ce3", rq(0,2) | rq(1,2), ALL, ALL, 1'b1, gv(2,0), L0);

    // reset mid-packet (ptr[2]=1 -> input 3 locks, ptr becomes 4)
    step("rm1", rq(3,2), L0, ALL, 1'b1, gv(2,3), L0);
    step("rm2", rq(3,2), L0, ALL, 1'b1, gv(2,3), L2);
    do_reset(1);
    step("rm3", rq(0,2) | rq(4,2), ALL, ALL, 1'b1, gv(2,0), L0);
    step("rm4", '0, L0, ALL, 1'b1, '0, L0);

`ifdef PIPE_LINE_SA_EN
    @(negedge clk);
    if (exp_q.size() > 0) pop_chk("flush");
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
